// File: rtl/sub_pkg.sv
// Shared types for the nibble-serial borrow-lookahead subtractor.
// Optional signed-overflow output is enabled with SUB_OVF_EN (see top).
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_bla.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - br_in, borrows flattened to SOP.
// Also exports group borrow-generate G / propagate P for higher-level lookahead.
module nibble_bla
    import sub_pkg::*;
(
    input  nibble_t x,
    input  nibble_t y,
    input  logic    br_in,
    output nibble_t d,
    output logic    br_out,
    output logic    G,
    output logic    P
);

    nibble_t g;
    nibble_t p;
    nibble_t br;

    assign g = ~x & y;
    assign p = ~(x ^ y);

    assign br[0] = br_in;
    assign br[1] = g[0] | (p[0] & br_in);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & br_in);

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

    assign br_out = G | (P & br_in);
    assign d      = x ^ y ^ br;

endmodule

// File: rtl/nibble_serial_bla_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock, LSB nibble first.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_bla_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    if ((WIDTH < NIBBLE_W) || (WIDTH % NIBBLE_W != 0)) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 4");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    nibble_t [N-1:0]     a_q, a_d;
    nibble_t [N-1:0]     b_q, b_d;
    nibble_t [N-1:0]     diff_q, diff_d;
    logic                br_q, br_d;
    logic                bout_q, bout_d;
`ifdef SUB_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    nibble_t nib_d;
    logic    nib_br;
    logic    grp_g, grp_p;
    logic    unused_grp;

    nibble_bla u_bla (
        .x      (a_q[idx_q]),
        .y      (b_q[idx_q]),
        .br_in  (br_q),
        .d      (nib_d),
        .br_out (nib_br),
        .G      (grp_g),
        .P      (grp_p)
    );

    // Group G/P are only needed when slices are chained in parallel.
    assign unused_grp = grp_g ^ grp_p;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    idx_d   = '0;
`ifdef SUB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[idx_q] = nib_d;
                br_d          = nib_br;
                idx_d         = idx_q + IDX_W'(1);
                if (idx_q == LAST) begin
                    bout_d  = nib_br;
`ifdef SUB_OVF_EN
                    ovf_d   = (a_q[N-1][NIBBLE_W-1] ^ b_q[N-1][NIBBLE_W-1])
                            & (nib_d[NIBBLE_W-1] ^ a_q[N-1][NIBBLE_W-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
